// File: rtl/data_memory.sv
// Word-organised data memory with byte-lane-masked stores and right-justified loads.
// Latency: combinational read path, stores commit on the rising clk edge.
// Backpressure: none; every access completes in the cycle it is presented.
module data_memory #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             misaligned,
    output logic             illegal,
    output logic             err_sticky
);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    idx;
    logic [1:0]       off;
    logic             is_load;
    logic             is_half;
    logic             is_word;
    logic [3:0]       be;
    logic [WIDTH-1:0] wdata_sh;
    logic             wr_en;
    logic             unused_addr;

    assign idx         = addr[AW+1:2];
    assign off         = addr[1:0];
    assign unused_addr = ^addr[WIDTH-1:AW+2];

    // Simultaneous read and write is a store, so load legality only applies without mem_write.
    assign is_load = mem_read && !mem_write;
    assign is_half = (funct3 == 3'b001) || (is_load && funct3 == 3'b101);
    assign is_word = (funct3 == 3'b010);

    assign rdata = mem[idx] >> {off, 3'b000};

    always_comb begin
        illegal = 1'b0;
        if (mem_write) begin
            illegal = !(funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010);
        end else if (mem_read) begin
            illegal = (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111);
        end
    end

    always_comb begin
        misaligned = 1'b0;
        if (mem_read || mem_write) begin
            misaligned = (is_half && addr[0]) || (is_word && off != 2'b00);
        end
    end

    always_comb begin
        be       = 4'b0000;
        wdata_sh = wdata;
        case (funct3)
            3'b000: begin
                be       = 4'b0001 << off;
                wdata_sh = wdata << {off, 3'b000};
            end
            3'b001: begin
                be       = 4'b0011 << {addr[1], 1'b0};
                wdata_sh = wdata << {addr[1], 4'b0000};
            end
            3'b010: be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    assign wr_en = mem_write && !misaligned && !illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sticky <= 1'b0;
        end else if (misaligned || illegal) begin
            err_sticky <= 1'b1;
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: reset, lane stores, loads, error flags, read-during-write.
module tb_data_memory;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        misaligned;
    logic        illegal;
    logic        err_sticky;

    int checks = 0;
    int errors = 0;

    data_memory #(.WIDTH(32), .DEPTH(256)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .misaligned (misaligned),
        .illegal    (illegal),
        .err_sticky (err_sticky)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        mem_read  = rd;
        mem_write = wr;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        step();
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_held_rdata got=%h exp=%h", rdata, 32'h0); end
        step();
        rst_n = 1'b1;
        step();
        drive(1'b1, 1'b0, 3'b010, 32'h0, 32'h0);
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rd_0x000 got=%h exp=%h", rdata, 32'h0); end
        drive(1'b1, 1'b0, 3'b010, 32'h3FC, 32'h0);
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rd_0x3FC got=%h exp=%h", rdata, 32'h0); end
        checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL reset_err_sticky got=%b exp=0", err_sticky); end
        drive(1'b0, 1'b0, 3'b010, 32'h11, 32'h0);
        checks++; if ({misaligned, illegal} !== 2'b00) begin errors++; $display("FAIL idle_flags got=%b exp=00", {misaligned, illegal}); end
    endtask

    task automatic test_word();
        drive(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        checks++; if ({misaligned, illegal} !== 2'b00) begin errors++; $display("FAIL sw_flags got=%b exp=00", {misaligned, illegal}); end
        step();
        drive(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        checks++; if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_0x10 got=%h exp=%h", rdata, 32'hDEADBEEF); end
        drive(1'b1, 1'b0, 3'b010, 32'h410, 32'h0);
        checks++; if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_wrap_0x410 got=%h exp=%h", rdata, 32'hDEADBEEF); end
        drive(1'b0, 1'b1, 3'b010, 32'h414, 32'hCAFEF00D);
        step();
        drive(1'b1, 1'b0, 3'b010, 32'h14, 32'h0);
        checks++; if (rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL sw_wrap_lw_0x14 got=%h exp=%h", rdata, 32'hCAFEF00D); end
    endtask

    task automatic test_lanes();
        drive(1'b0, 1'b1, 3'b000, 32'h12, 32'hAABBCC55);
        step();
        drive(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        checks++; if (rdata !== 32'hDE55BEEF) begin errors++; $display("FAIL sb_lw got=%h exp=%h", rdata, 32'hDE55BEEF); end
        drive(1'b0, 1'b1, 3'b001, 32'h10, 32'h99991234);
        step();
        drive(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        checks++; if (rdata !== 32'hDE551234) begin errors++; $display("FAIL sh_lw got=%h exp=%h", rdata, 32'hDE551234); end
        drive(1'b1, 1'b0, 3'b000, 32'h13, 32'h0);
        checks++; if (rdata !== 32'h000000DE) begin errors++; $display("FAIL lb_0x13 got=%h exp=%h", rdata, 32'h000000DE); end
        drive(1'b1, 1'b0, 3'b001, 32'h12, 32'h0);
        checks++; if (rdata !== 32'h0000DE55) begin errors++; $display("FAIL lh_0x12 got=%h exp=%h", rdata, 32'h0000DE55); end
        checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL lh_0x12_misaligned got=%b exp=0", misaligned); end
        drive(1'b1, 1'b0, 3'b100, 32'h11, 32'h0);
        checks++; if (rdata !== 32'h00DE5512) begin errors++; $display("FAIL lbu_0x11 got=%h exp=%h", rdata, 32'h00DE5512); end
        drive(1'b0, 1'b1, 3'b001, 32'h16, 32'h0000ABCD);
        step();
        drive(1'b1, 1'b0, 3'b010, 32'h14, 32'h0);
        checks++; if (rdata !== 32'hABCDF00D) begin errors++; $display("FAIL sh_upper_half got=%h exp=%h", rdata, 32'hABCDF00D); end
        checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL lanes_err_sticky got=%b exp=0", err_sticky); end
    endtask

    task automatic test_misaligned();
        drive(1'b0, 1'b1, 3'b010, 32'h11, 32'hFFFFFFFF);
        checks++; if ({misaligned, illegal} !== 2'b10) begin errors++; $display("FAIL sw_mis_flags got=%b exp=10", {misaligned, illegal}); end
        checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL sw_mis_sticky_pre got=%b exp=0", err_sticky); end
        step();
        drive(1'b0, 1'b0, 3'b000, 32'h10, 32'h0);
        checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL sw_mis_sticky_post got=%b exp=1", err_sticky); end
        checks++; if (rdata !== 32'hDE551234) begin errors++; $display("FAIL sw_mis_nowrite got=%h exp=%h", rdata, 32'hDE551234); end
        repeat (10) step();
        checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL sticky_held got=%b exp=1", err_sticky); end
        drive(1'b1, 1'b0, 3'b101, 32'h13, 32'h0);
        checks++; if (misaligned !== 1'b1) begin errors++; $display("FAIL lhu_mis got=%b exp=1", misaligned); end
        drive(1'b0, 1'b1, 3'b001, 32'h11, 32'h0000FFFF);
        checks++; if (misaligned !== 1'b1) begin errors++; $display("FAIL sh_mis got=%b exp=1", misaligned); end
        step();
        drive(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        checks++; if (rdata !== 32'hDE551234) begin errors++; $display("FAIL sh_mis_nowrite got=%h exp=%h", rdata, 32'hDE551234); end
    endtask

    task automatic test_illegal();
        do_reset();
        drive(1'b0, 1'b1, 3'b010, 32'h10, 32'h13579BDF);
        step();
        drive(1'b0, 1'b1, 3'b011, 32'h10, 32'hFFFFFFFF);
        checks++; if ({misaligned, illegal} !== 2'b01) begin errors++; $display("FAIL st_011_flags got=%b exp=01", {misaligned, illegal}); end
        checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL st_011_sticky_pre got=%b exp=0", err_sticky); end
        step();
        drive(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL st_011_sticky_post got=%b exp=1", err_sticky); end
        checks++; if (rdata !== 32'h13579BDF) begin errors++; $display("FAIL st_011_nowrite got=%h exp=%h", rdata, 32'h13579BDF); end
        drive(1'b1, 1'b0, 3'b110, 32'h10, 32'h0);
        checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL ld_110_illegal got=%b exp=1", illegal); end
        drive(1'b1, 1'b0, 3'b100, 32'h13, 32'h0);
        checks++; if ({misaligned, illegal} !== 2'b00) begin errors++; $display("FAIL lbu_legal got=%b exp=00", {misaligned, illegal}); end
        drive(1'b1, 1'b1, 3'b100, 32'h10, 32'hFFFFFFFF);
        checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL rdwr_store_legality got=%b exp=1", illegal); end
        checks++; if (rdata !== 32'h13579BDF) begin errors++; $display("FAIL rdwr_old_data got=%h exp=%h", rdata, 32'h13579BDF); end
        step();
        drive(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        checks++; if (rdata !== 32'h13579BDF) begin errors++; $display("FAIL rdwr_illegal_nowrite got=%h exp=%h", rdata, 32'h13579BDF); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(1'b0, 1'b1, 3'b010, 32'h20, 32'hA5A5A5A5);
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rdw_pre_edge got=%h exp=%h", rdata, 32'h0); end
        step();
        checks++; if (rdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL rdw_post_edge got=%h exp=%h", rdata, 32'hA5A5A5A5); end
        drive(1'b1, 1'b0, 3'b111, 32'h20, 32'h0);
        step();
        drive(1'b0, 1'b1, 3'b000, 32'h20, 32'h00000077);
        checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL pre_reset_sticky got=%b exp=1", err_sticky); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL midcycle_reset_rdata got=%h exp=%h", rdata, 32'h0); end
        checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL midcycle_reset_sticky got=%b exp=0", err_sticky); end
        step();
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 3'b000, 32'h20, 32'h0);
        step();
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_discards_sb got=%h exp=%h", rdata, 32'h0); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_lanes();
        test_misaligned();
        test_illegal();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
